// File: rtl/pwm_generator.sv
// PWM generator driven by rising edges of an upstream divided clock, with
// double-buffered period/duty. Define PWM_SYNC_LOAD_EN to defer reloads to period wraps.
module pwm_generator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clk_div,
    input  logic             enable,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             cfg_load,
    output logic             pwm_out,
    output logic             period_done,
    output logic             active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_clk_div_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm_out;
    logic             r_period_done;
    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_pend_period;
    logic [CNT_W-1:0] r_pend_duty;
    logic             r_pend_valid;

    logic             w_tick;
    logic             w_running;
    logic             w_period_zero;
    logic             w_wrap;
    logic             w_xfer_evt;
    logic             w_from_pend;
    logic             w_direct;
    logic             w_live_we;
    logic [CNT_W-1:0] w_live_period;
    logic [CNT_W-1:0] w_live_duty;
    logic [CNT_W-1:0] w_duty_cmp;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pwm_nxt;
    logic             w_done_nxt;

    assign w_tick        = clk_div & ~r_clk_div_q;
    assign w_running     = (r_state == RUN) || (r_state == DRAIN);
    assign w_period_zero = (r_period_sh == '0);
    // >= so that a counter stranded above a freshly shrunk period wraps on the next tick
    assign w_wrap        = !w_period_zero && (r_cnt >= r_period_sh - ONE);

    // A wrap is always a safe point to swap the live values; IDLE swaps immediately.
    assign w_xfer_evt = (r_state == IDLE) || (w_running && w_tick && w_wrap);
`ifdef PWM_SYNC_LOAD_EN
    assign w_from_pend = r_pend_valid && w_xfer_evt;
`else
    assign w_from_pend = r_pend_valid;
`endif
    assign w_direct      = cfg_load && w_xfer_evt;
    assign w_live_we     = w_direct || w_from_pend;
    assign w_live_period = w_direct ? cfg_period : r_pend_period;
    assign w_live_duty   = w_direct ? cfg_duty   : r_pend_duty;
    // The first tick of a new period compares against the duty being installed with it
    assign w_duty_cmp    = (w_wrap && w_live_we) ? w_live_duty : r_duty_sh;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pwm_nxt   = r_pwm_out;
        w_done_nxt  = 1'b0;
        w_cnt_inc   = w_wrap ? '0 : r_cnt + ONE;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_pwm_nxt = 1'b0;
                if (enable && !w_period_zero) begin
                    w_state_nxt = RUN;
                    w_pwm_nxt   = (r_duty_sh != '0);
                end
            end
            RUN, DRAIN: begin
                if (w_period_zero) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_pwm_nxt   = 1'b0;
                end else begin
                    if (w_tick) begin
                        w_cnt_nxt  = w_cnt_inc;
                        w_pwm_nxt  = (w_cnt_inc < w_duty_cmp);
                        w_done_nxt = w_wrap;
                    end
                    if (r_state == RUN) begin
                        if (!enable) w_state_nxt = DRAIN;
                    end else if (w_tick && w_wrap) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_pwm_nxt   = 1'b0;
                    end else if (enable) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_pwm_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_clk_div_q   <= 1'b0;
            r_cnt         <= '0;
            r_pwm_out     <= 1'b0;
            r_period_done <= 1'b0;
            r_period_sh   <= '0;
            r_duty_sh     <= '0;
            r_pend_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_clk_div_q   <= clk_div;
            r_cnt         <= w_cnt_nxt;
            r_pwm_out     <= w_pwm_nxt;
            r_period_done <= w_done_nxt;
            if (w_live_we) begin
                r_period_sh <= w_live_period;
                r_duty_sh   <= w_live_duty;
            end
            if (cfg_load && !w_direct) r_pend_valid <= 1'b1;
            else if (w_from_pend)      r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_load) begin
            r_pend_period <= cfg_period;
            r_pend_duty   <= cfg_duty;
        end
    end

    assign pwm_out     = r_pwm_out;
    assign period_done = r_period_done;
    assign active      = (r_state != IDLE);

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period, duty and counter registers.
REQ-002 SHALL have port clk, input, 1: system clock; the only clock.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port clk_div, input, 1: divided clock from the upstream clock divider, synchronous to clk.
REQ-005 SHALL have port enable, input, 1: run request, level-sensitive.
REQ-006 SHALL have port cfg_period, input, CNT_W: PWM period, in ticks.
REQ-007 SHALL have port cfg_duty, input, CNT_W: high time, in ticks.
REQ-008 SHALL have port cfg_load, input, 1: one-clk strobe that captures cfg_period and cfg_duty.
REQ-009 SHALL have port pwm_out, output, 1: PWM waveform, registered.
REQ-010 SHALL have port period_done, output, 1: one-clk pulse at each period wrap.
REQ-011 SHALL have port active, output, 1: high when the state is not IDLE.

Function
REQ-012 SHALL register clk_div into clk_div_q; tick = clk_div AND NOT clk_div_q, one clk wide per rising edge of clk_div.
REQ-013 SHALL hold live registers period_sh and duty_sh, which are the only values used for counting and comparison.
REQ-014 SHALL implement states IDLE, RUN and DRAIN, encoded in a 2-bit state register.
REQ-015 SHALL, in IDLE, drive pwm_out=0, hold cnt=0, and on enable=1 with period_sh!=0 go to RUN on the next clk with cnt=0 and pwm_out=(duty_sh!=0).
REQ-016 SHALL, in RUN or DRAIN on a tick, compute cnt_next = 0 if cnt==period_sh-1, else cnt+1, and register pwm_out=(cnt_next<duty_sh).
REQ-017 SHALL, on a wrap (cnt==period_sh-1 with tick), pulse period_done for exactly that following clk.
REQ-018 SHALL leave cnt, pwm_out and period_done unchanged on non-tick clks (period_done=0).
REQ-019 SHALL, in RUN with enable=0, go to DRAIN; the current period completes unchanged.
REQ-020 SHALL, in DRAIN, go to IDLE on wrap, with pwm_out=0 on the same edge; if enable returns to 1 before the wrap, go back to RUN without restarting cnt.
REQ-021 SHALL force pwm_out high for the whole period when duty_sh>=period_sh, and force it low when duty_sh==0.
REQ-022 SHALL, when period_sh==0 in RUN or DRAIN, go to IDLE on the next clk, with pwm_out=0 and no period_done.
REQ-023 SHALL, on cfg_load, capture the inputs into pend_period/pend_duty and set pend_valid; a later load overwrites the pending values.
REQ-024 SHALL copy pending values into the live registers (and clear pend_valid) whenever the state is IDLE.
REQ-025 SHALL, when cfg_load and the transfer event occur in the same clk, apply the cfg_* inputs directly to the live registers and leave pend_valid=0.
REQ-026 SHALL do all counter arithmetic in CNT_W bits, with no wrap beyond period_sh-1.

Reset
REQ-027 SHALL, on resetn=0 at a clk edge, set: state=IDLE; cnt=0; clk_div_q=0; pwm_out=0; period_done=0; active=0; period_sh=0; duty_sh=0; pend_valid=0.
REQ-028 SHALL, on reset mid-period, drop pwm_out to 0 on that edge with no period_done; pending loads are discarded.

Configuration
REQ-029 SHALL, with PWM_SYNC_LOAD_EN defined, transfer pending values to the live registers in RUN and DRAIN only on a wrap, so the waveform never glitches mid-period.
REQ-030 SHALL, without PWM_SYNC_LOAD_EN, transfer pending values on the clk after cfg_load in any state; comparison uses the new values from the next tick, and a cnt>=new period_sh-1 wraps on the next tick.

Verification
REQ-031 SHALL cover: load period=4, duty=1; enable; clk_div toggling every 2 clk -> pwm_out high 1 tick, low 3 ticks, and period_done once per 4 ticks.
REQ-032 SHALL cover: duty=0 -> pwm_out stays 0; duty=4 and duty=9 with period=4 -> pwm_out stays 1; period_done still pulses every 4 ticks.
REQ-033 SHALL cover: enable drops at cnt=1 with period=4 -> DRAIN, period finishes, IDLE after wrap, active=0, pwm_out=0; enable re-asserted at cnt=2 -> stays RUN with no restart.
REQ-034 SHALL cover: with PWM_SYNC_LOAD_EN, load duty=3 at cnt=1 (period=4, duty=1) -> current period unchanged and the next period is high for 3 ticks; without the macro -> duty changes within the current period.
REQ-035 SHALL cover: cfg_load coincident with a wrap (period=8, duty=2) -> the new values take effect at cnt=0 of the next period with pend_valid=0.
REQ-036 SHALL cover: resetn=0 at cnt=2 while pwm_out=1 -> pwm_out=0, cnt=0, state=IDLE on the same edge, period_sh=0, and no period_done pulse.
